alu_op_issue: RTL and testbench
===============================

# alu_op_issue

Decode-side producer of the execute-stage ALU interface in the RV32I pipeline. Takes the instruction in ID with its PC and register-file read data, generates the ALU operands A, B and the 4-bit ALU op, and holds them in the ID/EX pipeline register for the ALU in EX. It also implements the ID/EX stall and flush behaviour, so the ALU only ever sees registered, valid-qualified operands.

## Interface
- No parameters; XLEN is fixed at 32.
- `clk`  in  1  Pipeline clock; all state updates on the rising edge.
- `rst`  in  1  Reset, synchronous and active-high.
- `id_valid`  in  1  ID holds a real instruction this cycle.
- `id_inst`  in  32  Instruction word.
- `id_pc`  in  32  PC of `id_inst`.
- `id_rs1_data`  in  32  rs1 value, already forwarded.
- `id_rs2_data`  in  32  rs2 value, already forwarded.
- `stall`  in  1  Hold the ID/EX register.
- `flush`  in  1  Insert a bubble into EX.
- `ex_valid`  out  1  The EX-stage contents are a real instruction.
- `ex_a`  out  32  ALU operand A.
- `ex_b`  out  32  ALU operand B.
- `ex_op`  out  4  ALU op code.
- `ex_imm`  out  32  Sign-extended immediate, used by the branch-target adder.
- `ex_rs2_data`  out  32  Store data.
- `ex_rd`  out  5  Destination register.
- `ex_we`  out  1  Register write enable. It is forced to 0 when rd is x0 or the instruction is a branch or store.
- `ex_is_branch`  out  1  Conditional branch; the ALU `f` output decides whether it is taken.
- `ex_illegal`  out  1  The opcode is not in RV32I.

## Operation

**ALU op codes**
- ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7.
- EQ=8, NE=9, LT=A, GE=B, LTU=C, GEU=D.

**Decode, by opcode (combinational, then registered)**
- OP (0110011): A=rs1, B=rs2.
  - funct3 000 gives ADD, or SUB when funct7[5]=1.
  - 001 gives SLL; 010 gives LT; 011 gives LTU; 100 gives XOR.
  - 101 gives SRL, or SRA when funct7[5]=1.
  - 110 gives OR; 111 gives AND.
- OP-IMM (0010011): A=rs1, B=imm_i, same mapping as OP except:
  - funct3 000 always gives ADD.
  - For shifts, B = zero-extended shamt inst[24:20]; funct7[5] selects SRA.
- LOAD (0000011) and STORE (0100011): A=rs1, B=imm_i or imm_s respectively, op ADD.
- BRANCH (1100011): A=rs1, B=rs2.
  - funct3 000 gives EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU.
  - funct3 010 and 011 are illegal.
  - `ex_imm` = imm_b.
- LUI: A=0, B=imm_u, op ADD.
- AUIPC: A=pc, B=imm_u, op ADD.
- JAL and JALR: A=pc, B=4, op ADD. `ex_imm` = imm_j or imm_i respectively.
- Any other opcode: op ADD, A=B=0, `ex_we`=0, `ex_illegal`=1.

**Immediates** are sign-extended from inst[31] per the RV32I formats; imm_u = {inst[31:12], 12'b0}.

**Register update priority**
1. `rst`: all outputs go to 0. Since ADD=0, `ex_op` reads as ADD.
2. `flush`: `ex_valid`, `ex_we`, `ex_is_branch` and `ex_illegal` go to 0, `ex_op` to ADD, operands to 0. Flush wins over stall.
3. `stall`: every register holds its value.
4. Otherwise: load the decoded values. `ex_valid` takes `id_valid`. When `id_valid`=0, also clear `ex_we`, `ex_is_branch` and `ex_illegal`.

## Timing
- Latency is 1 cycle: an instruction presented in cycle N appears on the `ex_*` outputs in N+1.
- The `ex_*` outputs are register outputs only; there is no combinational path from ID inputs to outputs.
- A stall of any length holds the outputs constant. The instruction advances on the first cycle with `stall`=0.
- `flush` in the same cycle as `stall` produces a bubble on the next cycle.
- `rst` asserted mid-stream clears state on the next edge, regardless of `stall` or `flush`.

## Structure
- Shared package `alu_pkg` holds:
  - The 4-bit op-code localparams listed above.
  - RV32I opcode constants.
  - funct3 constants for the branch and arithmetic encodings.
- The ALU imports the same package, so the encoding stays consistent between producer and consumer.
- One sub-module, `imm_gen`, which is purely combinational: instruction in, imm_i, imm_s, imm_b, imm_u and imm_j out.

## Test plan
- **SUB:** `sub x3,x1,x2` (0x402081B3), rs1=7, rs2=9 → next cycle `ex_op`=1, `ex_a`=7, `ex_b`=9, `ex_rd`=3, `ex_we`=1.
- **SRAI:** `srai x5,x6,4` (0x40435293), rs1=0x80000000 → `ex_op`=7, `ex_b`=4. When fed to the ALU, C=0xF8000000.
- **BGEU:** `bgeu x1,x2,-8` (0xFE20FCE3) → `ex_op`=D, `ex_is_branch`=1, `ex_we`=0, `ex_imm`=0xFFFFFFF8.
- **AUIPC:** `auipc x1,0x12345` at pc=0x100 → `ex_a`=0x100, `ex_b`=0x12345000, `ex_op`=0.
- **Stall then flush:**
  - Stall 3 cycles → outputs are unchanged for those 3 cycles.
  - `stall`=1 and `flush`=1 together → next cycle `ex_valid`=0, `ex_op`=0, `ex_we`=0.
- **Illegal opcode and reset:**
  - Opcode 1111111 → `ex_illegal`=1, `ex_we`=0, `ex_op`=0.
  - `rst` pulsed mid-stream → all outputs 0 on the next edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Encodings shared by the decode-side issue logic and the EX-stage ALU:
// ALU op codes, RV32I opcodes, funct3 values and the ID/EX register layout.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_OR  = 4'h3;
  localparam logic [3:0] ALU_XOR = 4'h4;
  localparam logic [3:0] ALU_SLL = 4'h5;
  localparam logic [3:0] ALU_SRL = 4'h6;
  localparam logic [3:0] ALU_SRA = 4'h7;
  localparam logic [3:0] ALU_EQ  = 4'h8;
  localparam logic [3:0] ALU_NE  = 4'h9;
  localparam logic [3:0] ALU_LT  = 4'hA;
  localparam logic [3:0] ALU_GE  = 4'hB;
  localparam logic [3:0] ALU_LTU = 4'hC;
  localparam logic [3:0] ALU_GEU = 4'hD;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef struct packed {
    logic        valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] imm;
    logic [31:0] rs2_data;
    logic [4:0]  rd;
    logic        we;
    logic        is_branch;
    logic        illegal;
  } idex_t;

  // Register-register and register-immediate arithmetic share one mapping;
  // only the register form turns funct3 000 into SUB.
  function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt,
                                          input logic is_reg);
    logic [3:0] op;
    case (f3)
      F3_ADD:  op = (alt && is_reg) ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_LT;
      F3_SLTU: op = ALU_LTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_op_issue_imm_gen.sv
// RV32I immediate extraction; purely combinational. The opcode field is not
// needed, so only inst[31:7] comes in.
module imm_gen
  import alu_pkg::*;
(
  input  logic [31:7] inst_i,
  output logic [31:0] imm_i_o,
  output logic [31:0] imm_s_o,
  output logic [31:0] imm_b_o,
  output logic [31:0] imm_u_o,
  output logic [31:0] imm_j_o
);

  assign imm_i_o = {{20{inst_i[31]}}, inst_i[31:20]};
  assign imm_s_o = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign imm_b_o = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                    inst_i[11:8], 1'b0};
  assign imm_u_o = {inst_i[31:12], 12'b0};
  assign imm_j_o = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                    inst_i[30:21], 1'b0};

endmodule

// File: rtl/alu_op_issue.sv
// ID-stage operand/op generation for the ALU plus the ID/EX pipeline register
// with its stall and flush handling. All ex_* outputs come straight from flops.
module alu_op_issue
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [31:0] id_inst,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_rs1_data,
  input  logic [31:0] id_rs2_data,
  input  logic        stall,
  input  logic        flush,
  output logic        ex_valid,
  output logic [31:0] ex_a,
  output logic [31:0] ex_b,
  output logic [3:0]  ex_op,
  output logic [31:0] ex_imm,
  output logic [31:0] ex_rs2_data,
  output logic [4:0]  ex_rd,
  output logic        ex_we,
  output logic        ex_is_branch,
  output logic        ex_illegal
);

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        alt;
  logic [4:0]  rd;
  logic        legal, writes;
  idex_t       ex_d, ex_q;

  imm_gen u_imm_gen (
    .inst_i  (id_inst[31:7]),
    .imm_i_o (imm_i),
    .imm_s_o (imm_s),
    .imm_b_o (imm_b),
    .imm_u_o (imm_u),
    .imm_j_o (imm_j)
  );

  assign opcode = id_inst[6:0];
  assign funct3 = id_inst[14:12];
  assign alt    = id_inst[30];
  assign rd     = id_inst[11:7];

  always_comb begin
    ex_d          = '0;
    ex_d.valid    = id_valid;
    ex_d.rd       = rd;
    ex_d.rs2_data = id_rs2_data;
    ex_d.op       = ALU_ADD;
    legal         = 1'b1;
    writes        = 1'b1;
    case (opcode)
      OPC_OP: begin
        ex_d.a  = id_rs1_data;
        ex_d.b  = id_rs2_data;
        ex_d.op = arith_op(funct3, alt, 1'b1);
      end
      OPC_OP_IMM: begin
        ex_d.a   = id_rs1_data;
        ex_d.b   = (funct3 == F3_SLL || funct3 == F3_SR) ?
                   {27'b0, id_inst[24:20]} : imm_i;
        ex_d.op  = arith_op(funct3, alt, 1'b0);
        ex_d.imm = imm_i;
      end
      OPC_LOAD: begin
        ex_d.a   = id_rs1_data;
        ex_d.b   = imm_i;
        ex_d.imm = imm_i;
      end
      OPC_STORE: begin
        ex_d.a   = id_rs1_data;
        ex_d.b   = imm_s;
        ex_d.imm = imm_s;
        writes   = 1'b0;
      end
      OPC_BRANCH: begin
        ex_d.a         = id_rs1_data;
        ex_d.b         = id_rs2_data;
        ex_d.imm       = imm_b;
        ex_d.is_branch = 1'b1;
        writes         = 1'b0;
        case (funct3)
          F3_BEQ:  ex_d.op = ALU_EQ;
          F3_BNE:  ex_d.op = ALU_NE;
          F3_BLT:  ex_d.op = ALU_LT;
          F3_BGE:  ex_d.op = ALU_GE;
          F3_BLTU: ex_d.op = ALU_LTU;
          F3_BGEU: ex_d.op = ALU_GEU;
          default: legal   = 1'b0;
        endcase
      end
      OPC_LUI: begin
        ex_d.b   = imm_u;
        ex_d.imm = imm_u;
      end
      OPC_AUIPC: begin
        ex_d.a   = id_pc;
        ex_d.b   = imm_u;
        ex_d.imm = imm_u;
      end
      OPC_JAL, OPC_JALR: begin
        ex_d.a   = id_pc;
        ex_d.b   = 32'd4;
        ex_d.imm = (opcode == OPC_JAL) ? imm_j : imm_i;
      end
      default: legal = 1'b0;
    endcase
    // Anything undecodable becomes an inert ADD 0,0 that is flagged illegal.
    if (!legal) begin
      ex_d.a         = '0;
      ex_d.b         = '0;
      ex_d.op        = ALU_ADD;
      ex_d.imm       = '0;
      ex_d.is_branch = 1'b0;
      writes         = 1'b0;
    end
    ex_d.illegal = ~legal;
    ex_d.we      = writes && (rd != 5'd0);
    if (!id_valid) begin
      ex_d.we        = 1'b0;
      ex_d.is_branch = 1'b0;
      ex_d.illegal   = 1'b0;
    end
  end

  // ID/EX boundary: reset and flush both leave an all-zero bubble (op = ADD).
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= '0;
    end else if (flush) begin
      ex_q <= '0;
    end else if (!stall) begin
      ex_q <= ex_d;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_a         = ex_q.a;
  assign ex_b         = ex_q.b;
  assign ex_op        = ex_q.op;
  assign ex_imm       = ex_q.imm;
  assign ex_rs2_data  = ex_q.rs2_data;
  assign ex_rd        = ex_q.rd;
  assign ex_we        = ex_q.we;
  assign ex_is_branch = ex_q.is_branch;
  assign ex_illegal   = ex_q.illegal;

endmodule

// File: tb/tb_alu_op_issue.sv
// Randomized scoreboard bench for alu_op_issue with a behavioural decode model.
module tb_alu_op_issue;

  typedef struct packed {
    logic        valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] imm;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic        we;
    logic        br;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, id_valid, stall, flush;
  logic [31:0] id_inst, id_pc, id_rs1_data, id_rs2_data;
  logic        ex_valid, ex_we, ex_is_branch, ex_illegal;
  logic [31:0] ex_a, ex_b, ex_imm, ex_rs2_data;
  logic [3:0]  ex_op;
  logic [4:0]  ex_rd;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  exp_t model;

  always #5 clk = ~clk;

  alu_op_issue dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .stall(stall),
    .flush(flush), .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_op(ex_op),
    .ex_imm(ex_imm), .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd), .ex_we(ex_we),
    .ex_is_branch(ex_is_branch), .ex_illegal(ex_illegal)
  );

  // Reference decode: immediates built with arithmetic shifts and masks,
  // op codes from funct3-indexed tables.
  function automatic exp_t ref_decode(input logic [31:0] inst, input logic [31:0] pc,
                                      input logic [31:0] r1, input logic [31:0] r2,
                                      input logic v);
    logic [3:0]  arith [8];
    int          brtab [8];
    logic signed [31:0] s;
    logic [31:0] ii, is_, ib, iu, ij;
    logic [2:0]  f3;
    logic        legal, writes;
    exp_t        e;
    arith = '{4'h0, 4'h5, 4'hA, 4'hC, 4'h4, 4'h6, 4'h3, 4'h2};
    brtab = '{8, 9, -1, -1, 10, 11, 12, 13};
    s   = $signed(inst);
    ii  = 32'(s >>> 20);
    is_ = (32'(s >>> 20) & 32'hFFFF_FFE0) | {27'b0, inst[11:7]};
    ib  = (32'(s >>> 19) & 32'hFFFF_F000) | (32'(inst[7]) << 11) |
          (32'(inst[30:25]) << 5) | (32'(inst[11:8]) << 1);
    iu  = inst & 32'hFFFF_F000;
    ij  = (32'(s >>> 11) & 32'hFFF0_0000) | (inst & 32'h000F_F000) |
          (32'(inst[20]) << 11) | (32'(inst[30:21]) << 1);
    f3 = inst[14:12];
    e = '0;
    e.valid = v; e.rd = inst[11:7]; e.rs2 = r2;
    legal = 1'b1; writes = 1'b1;
    case (inst[6:0])
      7'h33: begin
        e.a = r1; e.b = r2; e.op = arith[f3];
        if (inst[30] && f3 == 3'd0) e.op = 4'h1;
        if (inst[30] && f3 == 3'd5) e.op = 4'h7;
      end
      7'h13: begin
        e.a = r1; e.imm = ii; e.op = arith[f3];
        e.b = (f3 == 3'd1 || f3 == 3'd5) ? 32'(inst[24:20]) : ii;
        if (inst[30] && f3 == 3'd5) e.op = 4'h7;
      end
      7'h03: begin e.a = r1; e.b = ii; e.imm = ii; end
      7'h23: begin e.a = r1; e.b = is_; e.imm = is_; writes = 1'b0; end
      7'h63: begin
        if (brtab[f3] < 0) legal = 1'b0;
        else begin
          e.a = r1; e.b = r2; e.imm = ib; e.op = 4'(brtab[f3]); e.br = 1'b1;
          writes = 1'b0;
        end
      end
      7'h37: begin e.b = iu; e.imm = iu; end
      7'h17: begin e.a = pc; e.b = iu; e.imm = iu; end
      7'h6F: begin e.a = pc; e.b = 32'd4; e.imm = ij; end
      7'h67: begin e.a = pc; e.b = 32'd4; e.imm = ii; end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      e.a = 0; e.b = 0; e.op = 0; e.imm = 0; e.br = 0; e.ill = 1'b1; writes = 1'b0;
    end
    e.we = writes && (e.rd != 0);
    if (!v) begin e.we = 0; e.br = 0; e.ill = 0; end
    return e;
  endfunction

  // Drive one cycle of inputs, advance the model and queue the expected
  // register contents for the following edge.
  task automatic step(input logic r, input logic f, input logic st, input logic v,
                      input logic [31:0] inst, input logic [31:0] pc,
                      input logic [31:0] r1, input logic [31:0] r2);
    rst = r; flush = f; stall = st; id_valid = v;
    id_inst = inst; id_pc = pc; id_rs1_data = r1; id_rs2_data = r2;
    if (r || f) model = '0;
    else if (!st) model = ref_decode(inst, pc, r1, r2, v);
    sb_q.push_back(model);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0] opcs [10];
    logic [31:0] w;
    opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h7F};
    w = $urandom;
    if ($urandom_range(0, 9) != 0) w[6:0] = opcs[$urandom_range(0, 9)];
    return w;
  endfunction

  initial begin : monitor
    exp_t e, act;
    forever begin
      @(posedge clk);
      #1;
      act = '{ex_valid, ex_a, ex_b, ex_op, ex_imm, ex_rs2_data, ex_rd, ex_we,
              ex_is_branch, ex_illegal};
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty at %0t", $time);
      end else begin
        e = sb_q.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL idex_regs at %0t: got v=%b a=%h b=%h op=%h imm=%h rs2=%h rd=%0d we=%b br=%b ill=%b, want v=%b a=%h b=%h op=%h imm=%h rs2=%h rd=%0d we=%b br=%b ill=%b",
                   $time, act.valid, act.a, act.b, act.op, act.imm, act.rs2, act.rd,
                   act.we, act.br, act.ill, e.valid, e.a, e.b, e.op, e.imm, e.rs2,
                   e.rd, e.we, e.br, e.ill);
        end
      end
    end
  end

  initial begin : driver
    logic [31:0] held;
    model = '0;
    step(1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
    step(1, 0, 0, 1, 32'h402081B3, 32'h40, 32'd7, 32'd9);
    step(0, 0, 0, 1, 32'h402081B3, 32'h40, 32'd7, 32'd9);         // sub x3,x1,x2
    step(0, 0, 0, 1, 32'h40435293, 32'h44, 32'h8000_0000, 32'h1); // srai x5,x6,4
    step(0, 0, 0, 1, 32'hFE20FCE3, 32'h48, 32'h5, 32'h6);         // bgeu x1,x2,-8
    step(0, 0, 0, 1, 32'h12345097, 32'h100, 32'h0, 32'h0);        // auipc x1,0x12345
    step(0, 0, 0, 1, 32'h00A00093, 32'h104, 32'h3, 32'h4);        // addi x1,x0,10
    for (int i = 0; i < 3; i++)
      step(0, 0, 1, 1, rand_inst(), $urandom, $urandom, $urandom);
    step(0, 1, 1, 1, 32'h402081B3, 32'h110, 32'd1, 32'd2);
    step(0, 0, 0, 1, 32'h0000007F, 32'h114, 32'h11, 32'h22);      // illegal opcode
    step(0, 0, 0, 1, 32'h0000A0E3, 32'h118, 32'h11, 32'h22);      // branch funct3 010
    step(0, 0, 0, 0, 32'h402081B3, 32'h11C, 32'h11, 32'h22);      // invalid slot
    step(0, 0, 0, 1, 32'h00B52023, 32'h120, 32'h11, 32'h22);      // sw x11,0(x10)
    step(0, 0, 0, 1, 32'h00000033, 32'h124, 32'h11, 32'h22);      // add x0,x0,x0
    step(1, 1, 1, 1, 32'h402081B3, 32'h128, 32'h11, 32'h22);      // reset mid-stream
    step(1, 0, 1, 1, 32'h402081B3, 32'h12C, 32'h11, 32'h22);
    for (int i = 0; i < 600; i++) begin
      held = rand_inst();
      step($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 4) == 0, $urandom_range(0, 7) != 0,
           held, $urandom, $urandom, $urandom);
    end
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
